// File: rtl/term_tile_cfg.sv
// North-edge termination tile: loops N_IN back to S_OUT with a per-channel mode
// (tie-low/pass/registered/stretch) from config frames. Optional macro: TERM_EMULATION_EN.
module term_tile_cfg #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NUM_CH          = 16,
    parameter int STRETCH         = 3,
    parameter logic [((2*NUM_CH+FrameBitsPerRow-1)/FrameBitsPerRow)*FrameBitsPerRow-1:0]
                  Emulate_Bitstream = '0
) (
    input  logic                       UserCLK,
    input  logic                       UserRSTn,
    input  logic [NUM_CH-1:0]          N_IN,
    output logic [NUM_CH-1:0]          S_OUT,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       UserCLKo
);

    localparam int NUM_FRAMES = (2*NUM_CH + FrameBitsPerRow - 1) / FrameBitsPerRow;
    localparam int FLAT_W     = NUM_FRAMES * FrameBitsPerRow;
    localparam int CNT_W      = $clog2(STRETCH + 1);
    localparam logic [CNT_W-1:0] STRETCH_VAL = CNT_W'(STRETCH);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [1:0] MODE_TIE  = 2'b00;
    localparam logic [1:0] MODE_PASS = 2'b01;
    localparam logic [1:0] MODE_REG  = 2'b10;
    localparam logic [1:0] MODE_STR  = 2'b11;

    generate
        if (NUM_FRAMES > MaxFramesPerCol) begin : g_bad_frames
            $error("term_tile_cfg: NUM_FRAMES exceeds MaxFramesPerCol");
        end
        if (STRETCH < 1 || STRETCH > 255) begin : g_bad_stretch
            $error("term_tile_cfg: STRETCH must be in 1..255");
        end
    endgenerate

    // Pure feed-through of the configuration chain and clock; never reset.
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;
    assign UserCLKo      = UserCLK;

    logic [FLAT_W-1:0] cfg_flat;

`ifdef TERM_EMULATION_EN
    assign cfg_flat = Emulate_Bitstream;
`else
    logic [FrameBitsPerRow-1:0] cfg_frame_reg [NUM_FRAMES];

    for (genvar gi = 0; gi < NUM_FRAMES; gi++) begin : g_frame
        always_ff @(posedge UserCLK or negedge UserRSTn) begin
            if (!UserRSTn) begin
                cfg_frame_reg[gi] <= '0;
            end else if (FrameStrobe[gi]) begin
                cfg_frame_reg[gi] <= FrameData;
            end
        end
        assign cfg_flat[gi*FrameBitsPerRow +: FrameBitsPerRow] = cfg_frame_reg[gi];
    end

    logic unused_emu;
    assign unused_emu = ^Emulate_Bitstream;
`endif

    // Padding bits of the last frame carry no channel mode.
    generate
        if (FLAT_W > 2*NUM_CH) begin : g_pad
            logic unused_cfg_pad;
            assign unused_cfg_pad = ^cfg_flat[FLAT_W-1:2*NUM_CH];
        end
    endgenerate

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [1:0]       mode;
        logic             q_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;

        assign mode = cfg_flat[2*gi +: 2];

        // q samples every cycle so entering registered mode shows live data.
        always_ff @(posedge UserCLK or negedge UserRSTn) begin
            if (!UserRSTn) begin
                q_reg <= 1'b0;
            end else begin
                q_reg <= N_IN[gi];
            end
        end

        always_comb begin
            cnt_next = cnt_reg;
            if (mode != MODE_STR) begin
                cnt_next = '0;
            end else if (N_IN[gi]) begin
                cnt_next = STRETCH_VAL;
            end else if (cnt_reg != '0) begin
                cnt_next = cnt_reg - CNT_ONE;
            end
        end

        always_ff @(posedge UserCLK or negedge UserRSTn) begin
            if (!UserRSTn) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end

        always_comb begin
            S_OUT[gi] = 1'b0;
            case (mode)
                MODE_TIE:  S_OUT[gi] = 1'b0;
                MODE_PASS: S_OUT[gi] = N_IN[gi];
                MODE_REG:  S_OUT[gi] = q_reg;
                MODE_STR:  S_OUT[gi] = N_IN[gi] | (cnt_reg != '0);
                default:   S_OUT[gi] = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_term_tile_cfg.sv
// Scoreboard bench for term_tile_cfg: a 16-channel and a 32-channel instance,
// expected S_OUT values queued at drive time and checked mid-cycle.
module tb_term_tile_cfg;

    logic        clk;
    logic        rst_n;
    logic [15:0] n_in;
    logic [15:0] s_out;
    logic [31:0] fd;
    logic [19:0] fs;
    logic [31:0] fd_o;
    logic [19:0] fs_o;
    logic        clk_o;

    logic [31:0] n32;
    logic [31:0] s32;
    logic [31:0] fd32;
    logic [19:0] fs32;
    logic [31:0] fd32_o;
    logic [19:0] fs32_o;
    logic        clk32_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    term_tile_cfg #(.NUM_CH(16), .STRETCH(3)) dut (
        .UserCLK(clk), .UserRSTn(rst_n), .N_IN(n_in), .S_OUT(s_out),
        .FrameData(fd), .FrameStrobe(fs), .FrameData_O(fd_o),
        .FrameStrobe_O(fs_o), .UserCLKo(clk_o)
    );

    term_tile_cfg #(.NUM_CH(32), .STRETCH(3)) dut32 (
        .UserCLK(clk), .UserRSTn(rst_n), .N_IN(n32), .S_OUT(s32),
        .FrameData(fd32), .FrameStrobe(fs32), .FrameData_O(fd32_o),
        .FrameStrobe_O(fs32_o), .UserCLKo(clk32_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end else begin
            $display("ok   %s obs=%h", tag, obs);
        end
    endtask

    // One cycle on the 16-channel tile: drive after the edge, check at the falling edge.
    task automatic step(input string tag, input logic [15:0] n, input logic [19:0] strobe,
                        input logic [31:0] data, input logic [15:0] exp);
        logic [31:0] e;
        string       t;
        @(posedge clk);
        #1;
        n_in = n; fs = strobe; fd = data;
        exp_q.push_back({16'h0, exp});
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {16'h0, s_out}, e);
    endtask

    task automatic step32(input string tag, input logic [31:0] n, input logic [19:0] strobe,
                          input logic [31:0] data, input logic [31:0] exp);
        logic [31:0] e;
        string       t;
        @(posedge clk);
        #1;
        n32 = n; fs32 = strobe; fd32 = data;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, s32, e);
    endtask

    initial begin
        rst_n = 1'b0;
        n_in  = 16'hFFFF;
        fs    = '0;
        fd    = 32'hCAFE_F00D;
        n32   = '0;
        fs32  = '0;
        fd32  = '0;

        repeat (2) @(negedge clk);
        check("rst_sout", {16'h0, s_out}, 32'h0);
        check("rst_fwd_data", fd_o, 32'hCAFE_F00D);
        check("clk_fwd_low", {31'h0, clk_o}, 32'h0);
        fd = '0;
        rst_n = 1'b1;

        // Pass mode after release
        step("rel_wr",   16'hFFFF, 20'h00001, 32'h5555_5555, 16'h0000);
        step("pass_ff",  16'hFFFF, 20'h0,     32'h0,         16'hFFFF);
        step("pass_pat", 16'h1234, 20'h0,     32'h0,         16'h1234);

        // Strobe beyond NUM_FRAMES must not touch config
        step("bnd_wr",   16'h00F0, 20'h00002, 32'hFFFF_FFFF, 16'h00F0);
        check("bnd_fwd_strobe", {12'h0, fs_o}, 32'h0000_0002);
        check("bnd_fwd_data",   fd_o,          32'hFFFF_FFFF);
        step("bnd_hold", 16'h0F00, 20'h0,     32'h0,         16'h0F00);

        // Registered mode: entry shows current q, then 1-cycle latency
        step("reg_wr",    16'h00F0, 20'h00001, 32'hAAAA_AAAA, 16'h00F0);
        step("reg_entry", 16'h0000, 20'h0,     32'h0,         16'h00F0);
        step("reg_zero",  16'h0000, 20'h0,     32'h0,         16'h0000);
        step("reg_in",    16'h0001, 20'h0,     32'h0,         16'h0000);
        step("reg_out",   16'h0000, 20'h0,     32'h0,         16'h0001);
        step("reg_end",   16'h0000, 20'h0,     32'h0,         16'h0000);

        // Stretch mode, STRETCH=3: one-cycle pulse is high for 4 cycles
        step("str_wr",   16'h0000, 20'h00001, 32'hFFFF_FFFF, 16'h0000);
        step("str_idle", 16'h0000, 20'h0,     32'h0,         16'h0000);
        step("str_p0",   16'h0020, 20'h0,     32'h0,         16'h0020);
        step("str_p1",   16'h0000, 20'h0,     32'h0,         16'h0020);
        step("str_p2",   16'h0000, 20'h0,     32'h0,         16'h0020);
        step("str_p3",   16'h0000, 20'h0,     32'h0,         16'h0020);
        step("str_p4",   16'h0000, 20'h0,     32'h0,         16'h0000);

        // Retrigger at cycle 2
        step("rtg_c0", 16'h0020, 20'h0, 32'h0, 16'h0020);
        step("rtg_c1", 16'h0000, 20'h0, 32'h0, 16'h0020);
        step("rtg_c2", 16'h0020, 20'h0, 32'h0, 16'h0020);
        step("rtg_c3", 16'h0000, 20'h0, 32'h0, 16'h0020);
        step("rtg_c4", 16'h0000, 20'h0, 32'h0, 16'h0020);
        step("rtg_c5", 16'h0000, 20'h0, 32'h0, 16'h0020);
        step("rtg_c6", 16'h0000, 20'h0, 32'h0, 16'h0000);

        // Asynchronous reset between edges while stretching
        step("pre_rst", 16'h0020, 20'h0, 32'h0, 16'h0020);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_sout", {16'h0, s_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_cfg", 16'hFFFF, 20'h0, 32'h0, 16'h0000);

        // Two-frame instance: both frames pass, then frame 1 back to tie-low
        n_in = '0;
        step32("m_wr",   32'hFFFF_FFFF, 20'h00003, 32'h5555_5555, 32'h0000_0000);
        step32("m_pass", 32'hFFFF_FFFF, 20'h0,     32'h0,         32'hFFFF_FFFF);
        step32("m_pat",  32'hA5A5_0F0F, 20'h00002, 32'h0,         32'hA5A5_0F0F);
        step32("m_tie1", 32'hA5A5_0F0F, 20'h0,     32'h0,         32'h0000_0F0F);

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover obs=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/term_tile_cfg.md
# term_tile_cfg

Parametrised north-edge termination tile for the FABulous fabric. It loops NUM_CH incoming north wires back out as south wires, with a per-channel mode selected from configuration frames written over FrameData/FrameStrobe: tie-low, pass, registered or pulse-stretch. It sits at the top edge of a column and forwards the configuration chain and the user clock unchanged to the next tile.

## Interface
Parameters:
- MaxFramesPerCol, 20, width of the FrameStrobe bus.
- FrameBitsPerRow, 32, width of the FrameData bus.
- NUM_CH, 16, number of looped channels.
- STRETCH, 3, extra high cycles in pulse-stretch mode; range 1..255.
- NUM_FRAMES, derived as ceil(2*NUM_CH/FrameBitsPerRow). Elaboration error if NUM_FRAMES > MaxFramesPerCol.
- Emulate_Bitstream, 0, NUM_FRAMES*FrameBitsPerRow bits. Used only under TERM_EMULATION_EN.

Ports:
- UserCLK  in  1  single clock; all state is rising-edge.
- UserRSTn  in  1  reset, asynchronous assert, active-low.
- N_IN  in  NUM_CH  incoming north wires.
- S_OUT  out  NUM_CH  outgoing south wires.
- FrameData  in  FrameBitsPerRow  configuration data.
- FrameStrobe  in  MaxFramesPerCol  per-frame write strobes.
- FrameData_O  out  FrameBitsPerRow  equals FrameData, combinational.
- FrameStrobe_O  out  MaxFramesPerCol  equals FrameStrobe, combinational.
- UserCLKo  out  1  equals UserCLK, buffered.

## Operation
Configuration storage:
- NUM_FRAMES registers, cfg_frame[f], each FrameBitsPerRow wide. All clear on reset.
- At each rising edge, every f < NUM_FRAMES with FrameStrobe[f]=1 loads FrameData.
- Several strobes high in one cycle write every selected frame with the same data.
- Strobes at index NUM_FRAMES or above are ignored; they are only forwarded.

Mode bits:
- The frames are concatenated as the flat vector {cfg_frame[NUM_FRAMES-1], ..., cfg_frame[0]}.
- Channel c uses flat bits [2c+1:2c] as its mode.

Modes, per channel c:
- 00, tie-low: S_OUT[c]=0. This is the reset and default mode.
- 01, pass: S_OUT[c]=N_IN[c], combinational.
- 10, registered: S_OUT[c]=q[c], where q[c] samples N_IN[c] every cycle in all modes. q clears on reset.
- 11, stretch: S_OUT[c] = N_IN[c] | (cnt[c]!=0).
  - cnt[c] is clog2(STRETCH+1) bits wide and clears on reset.
  - N_IN[c]=1 loads STRETCH.
  - Otherwise cnt[c] decrements to 0 and saturates there.
  - In any mode other than 11, cnt[c] is forced to 0 on the next edge.

Mode changes:
- A new mode takes effect at S_OUT from the cycle after the frame write edge.
- Entering 10 immediately shows the current q; there is no flush.
- Entering 11 starts with cnt=0.

## Timing
- Frame write: visible in cfg_frame one edge after the strobe.
- Latency in mode 01: 0 cycles.
- Latency in mode 10: 1 cycle.
- Mode 11: rising input appears at output in 0 cycles. The output falls STRETCH cycles after the input falls.
- A new input pulse while cnt>0 reloads STRETCH, so the stretch is retriggerable.
- Reset mid-operation clears all cfg_frame, q and cnt asynchronously. S_OUT goes to 0 immediately, since all channels return to mode 00.
- Reset deassertion is synchronised externally. The first frame write is honoured on the first edge after release.
- FrameData_O, FrameStrobe_O and UserCLKo are unaffected by reset.

## Configuration
Macro TERM_EMULATION_EN:
- Defined: cfg_frame is a constant taken from Emulate_Bitstream, with frame f = bits [f*FrameBitsPerRow +: FrameBitsPerRow]. FrameStrobe writes are ignored. Reset does not clear configuration; q and cnt still reset.
- Undefined: storage is written by frames as specified above, and Emulate_Bitstream is unused.

## Test plan
- Reset: hold UserRSTn=0 with N_IN all ones -> S_OUT=0. Release, then strobe frame 0 with 0x55555555 -> S_OUT follows N_IN combinationally from the next cycle.
- Registered mode: write 0xAAAAAAAA, then drive N_IN=0x0001 for one cycle -> S_OUT[0] is high exactly one cycle later, for one cycle.
- Stretch mode: write 0xFFFFFFFF with STRETCH=3. Pulse N_IN[5] for one cycle -> S_OUT[5] is high for 4 cycles. Re-pulse at cycle 2 -> high until 3 cycles after the second pulse falls.
- Strobe bounds: with NUM_CH=16, drive FrameStrobe=0x00002 and FrameData=0xFFFFFFFF -> no S_OUT change. FrameStrobe_O=0x00002 and FrameData_O=0xFFFFFFFF in the same cycle.
- Multi-frame: with NUM_CH=32 and FrameBitsPerRow=32, strobe 0x3 with 0x55555555 -> all 32 channels in pass mode.
- Asynchronous reset mid-stretch: assert UserRSTn=0 between edges -> S_OUT=0 immediately. After release, the configuration reads all zeros.
